// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: decodes scan-code set 2 bytes into key events with
// a one-deep valid/ready holding register, and runs the ED/mask LED command
// with ACK checking, FE resend and per-state timeout.
module ps2_kbd_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 2000000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       tx_done_tick,
    output logic       tx_write,
    output logic [7:0] tx_data,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    output logic       led_busy,
    output logic       led_err,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_ovf
);

    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TIMEOUT - 1);
    localparam logic [RtyW-1:0] RtyMax  = RtyW'(MAX_RETRY);

    typedef enum logic {DIdle, DPause} dec_state_e;
    typedef enum logic [2:0] {CIdle, CWaitTx1, CWaitAck1, CWaitTx2, CWaitAck2} cmd_state_e;

    dec_state_e dec_q, dec_d;
    cmd_state_e cmd_q, cmd_d;

    logic [2:0]      skip_q, skip_d;
    logic            ext_q, ext_d, brk_q, brk_d, emit;
    logic            key_valid_q, key_valid_d, key_ext_q, key_ext_d;
    logic            key_break_q, key_break_d, key_ovf_q, key_ovf_d;
    logic [7:0]      key_code_q, key_code_d;
    logic            tx_write_q, tx_write_d, led_err_q, led_err_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [2:0]      mask_q, mask_d;
    logic [RtyW-1:0] retry_q, retry_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic rx_fa, rx_fe, dec_byte, tmo_hit, retry_ok;

    // FA/FE only matter to the command FSM; outside an ACK wait they are dropped.
    assign rx_fa    = rx_done_tick && (rx_data == 8'hFA);
    assign rx_fe    = rx_done_tick && (rx_data == 8'hFE);
    assign dec_byte = rx_done_tick && (rx_data != 8'hFA) && (rx_data != 8'hFE);
    assign tmo_hit  = (tmo_q == TmoLast);
    assign retry_ok = (retry_q < RtyMax);

    // Scan-code decoder: prefix flags and pause-sequence skipping.
    always_comb begin
        dec_d  = dec_q;
        skip_d = skip_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        emit   = 1'b0;
        if (dec_byte) begin
            if (dec_q == DPause) begin
                skip_d = skip_q + 3'd1;
                if (skip_q == 3'd6) begin
                    dec_d  = DIdle;
                    skip_d = 3'd0;
                end
            end else begin
                unique case (rx_data)
                    8'hE0: ext_d = 1'b1;
                    8'hF0: brk_d = 1'b1;
                    8'hE1: begin
                        dec_d  = DPause;
                        skip_d = 3'd0;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end
                    8'hAA, 8'hEE, 8'h00, 8'hFF: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        emit  = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // One-deep event holding register with overflow drop.
    always_comb begin
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        key_ovf_d   = 1'b0;
        if (emit) begin
            if (!key_valid_q || key_ready) begin
                key_valid_d = 1'b1;
                key_code_d  = rx_data;
                key_ext_d   = ext_q;
                key_break_d = brk_q;
            end else begin
                key_ovf_d = 1'b1;
            end
        end else if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
    end

    // Decoder and event register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_q       <= DIdle;
            skip_q      <= 3'd0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            key_ovf_q   <= 1'b0;
        end else begin
            dec_q       <= dec_d;
            skip_q      <= skip_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_break_q <= key_break_d;
            key_ovf_q   <= key_ovf_d;
        end
    end

    // Command FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cmd_q <= CIdle;
        else        cmd_q <= cmd_d;
    end

    // Command FSM next state; a qualifying strobe takes priority over timeout.
    always_comb begin
        cmd_d = cmd_q;
        unique case (cmd_q)
            CIdle:     if (led_req) cmd_d = CWaitTx1;
            CWaitTx1:  if (tx_done_tick) cmd_d = CWaitAck1;
                       else if (tmo_hit) cmd_d = CIdle;
            CWaitAck1: if (rx_fa) cmd_d = CWaitTx2;
                       else if (rx_fe) cmd_d = retry_ok ? CWaitTx1 : CIdle;
                       else if (tmo_hit) cmd_d = CIdle;
            CWaitTx2:  if (tx_done_tick) cmd_d = CWaitAck2;
                       else if (tmo_hit) cmd_d = CIdle;
            CWaitAck2: if (rx_fa) cmd_d = CIdle;
                       else if (rx_fe) cmd_d = retry_ok ? CWaitTx2 : CIdle;
                       else if (tmo_hit) cmd_d = CIdle;
            default:   cmd_d = CIdle;
        endcase
    end

    // Command FSM outputs: write strobe, byte to send, retry and timeout counters.
    always_comb begin
        tx_write_d = 1'b0;
        tx_data_d  = tx_data_q;
        mask_d     = mask_q;
        retry_d    = retry_q;
        tmo_d      = '0;
        if (cmd_q != CIdle && cmd_d == cmd_q) tmo_d = tmo_q + 1'b1;
        unique case (cmd_q)
            CIdle: if (led_req) begin
                mask_d     = led_mask;
                retry_d    = '0;
                tx_write_d = 1'b1;
                tx_data_d  = 8'hED;
            end
            CWaitAck1: if (rx_fa) begin
                retry_d    = '0;
                tx_write_d = 1'b1;
                tx_data_d  = {5'b0, mask_q};
            end else if (rx_fe && retry_ok) begin
                retry_d    = retry_q + 1'b1;
                tx_write_d = 1'b1;
                tx_data_d  = 8'hED;
            end
            CWaitAck2: if (rx_fa) begin
                retry_d = '0;
            end else if (rx_fe && retry_ok) begin
                retry_d    = retry_q + 1'b1;
                tx_write_d = 1'b1;
                tx_data_d  = {5'b0, mask_q};
            end
            default: ;
        endcase
        // Any return to idle other than the final FA is an abort.
        led_err_d = (cmd_q != CIdle) && (cmd_d == CIdle) && !(cmd_q == CWaitAck2 && rx_fa);
    end

    // Command datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_write_q <= 1'b0;
            tx_data_q  <= 8'h00;
            led_err_q  <= 1'b0;
            mask_q     <= 3'd0;
            retry_q    <= '0;
            tmo_q      <= '0;
        end else begin
            tx_write_q <= tx_write_d;
            tx_data_q  <= tx_data_d;
            led_err_q  <= led_err_d;
            mask_q     <= mask_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
        end
    end

    assign tx_write  = tx_write_q;
    assign tx_data   = tx_data_q;
    assign led_busy  = (cmd_q != CIdle);
    assign led_err   = led_err_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign key_break = key_break_q;
    assign key_ovf   = key_ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural model.
module tb_ps2_kbd_ctrl;

    localparam int unsigned ACK_TIMEOUT = 100;
    localparam int unsigned MAX_RETRY   = 2;

    logic       clk, reset;
    logic       rx_done_tick, tx_done_tick, tx_write, led_req, led_busy, led_err;
    logic [7:0] rx_data, tx_data, key_code;
    logic [2:0] led_mask;
    logic       key_valid, key_ready, key_ext, key_break, key_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_kbd_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .tx_done_tick(tx_done_tick), .tx_write(tx_write), .tx_data(tx_data),
        .led_req(led_req), .led_mask(led_mask), .led_busy(led_busy), .led_err(led_err),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break), .key_ovf(key_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Outputs as they must look after each clock edge.
    logic       m_txw, m_busy, m_err, m_kv, m_kext, m_kbrk, m_ovf;
    logic [7:0] m_txd, m_code;
    // Decoder: bytes still to swallow after E1, pending prefixes.
    int         m_pause;
    logic       m_pre_ext, m_pre_brk;
    // Command: which byte (0=ED,1=mask), waiting for ACK?, sends of this byte,
    // cycles spent in the current wait.
    int         m_idx, m_sends, m_elapsed;
    logic       m_wack;
    logic [2:0] m_mask;
    logic       emit, progressed;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            {m_txw, m_busy, m_err, m_kv, m_kext, m_kbrk, m_ovf} = '0;
            m_txd = 8'h00; m_code = 8'h00; m_pause = 0;
            m_pre_ext = 0; m_pre_brk = 0; m_idx = 0; m_sends = 0; m_elapsed = 0;
            m_wack = 0; m_mask = 0;
        end else begin
            emit = 0;
            if (rx_done_tick && rx_data != 8'hFA && rx_data != 8'hFE) begin
                if (m_pause > 0) m_pause--;
                else if (rx_data == 8'hE0) m_pre_ext = 1;
                else if (rx_data == 8'hF0) m_pre_brk = 1;
                else if (rx_data == 8'hE1) begin
                    m_pause = 7; m_pre_ext = 0; m_pre_brk = 0;
                end else if (rx_data inside {8'hAA, 8'hEE, 8'h00, 8'hFF}) begin
                    m_pre_ext = 0; m_pre_brk = 0;
                end else emit = 1;
            end
            m_ovf = 0;
            if (emit) begin
                if (!m_kv || key_ready) begin
                    m_kv = 1; m_code = rx_data; m_kext = m_pre_ext; m_kbrk = m_pre_brk;
                end else m_ovf = 1;
                m_pre_ext = 0; m_pre_brk = 0;
            end else if (m_kv && key_ready) m_kv = 0;

            m_txw = 0; m_err = 0;
            if (!m_busy) begin
                if (led_req) begin
                    m_busy = 1; m_idx = 0; m_wack = 0; m_sends = 1; m_elapsed = 0;
                    m_mask = led_mask; m_txw = 1; m_txd = 8'hED;
                end
            end else begin
                progressed = 0;
                if (!m_wack && tx_done_tick) begin
                    progressed = 1; m_wack = 1; m_elapsed = 0;
                end else if (m_wack && rx_done_tick && rx_data == 8'hFA) begin
                    progressed = 1;
                    if (m_idx == 0) begin
                        m_idx = 1; m_wack = 0; m_sends = 1; m_elapsed = 0;
                        m_txw = 1; m_txd = {5'b0, m_mask};
                    end else m_busy = 0;
                end else if (m_wack && rx_done_tick && rx_data == 8'hFE) begin
                    progressed = 1;
                    if (m_sends <= int'(MAX_RETRY)) begin
                        m_sends++; m_wack = 0; m_elapsed = 0; m_txw = 1;
                        m_txd = (m_idx == 0) ? 8'hED : {5'b0, m_mask};
                    end else begin
                        m_busy = 0; m_err = 1;
                    end
                end
                if (!progressed) begin
                    m_elapsed++;
                    if (m_elapsed == int'(ACK_TIMEOUT)) begin
                        m_busy = 0; m_err = 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (reset) begin
            n_checks++;
            if ({tx_write, tx_data, led_busy, led_err, key_valid, key_code, key_ext, key_break,
                 key_ovf} !== {m_txw, m_txd, m_busy, m_err, m_kv, m_code, m_kext, m_kbrk, m_ovf})
            begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got txw=%b txd=%h busy=%b err=%b kv=%b code=%h ext=%b brk=%b ovf=%b, required txw=%b txd=%h busy=%b err=%b kv=%b code=%h ext=%b brk=%b ovf=%b",
                         $time, tx_write, tx_data, led_busy, led_err, key_valid, key_code,
                         key_ext, key_break, key_ovf, m_txw, m_txd, m_busy, m_err, m_kv,
                         m_code, m_kext, m_kbrk, m_ovf);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
    endtask

    task automatic txdone();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic start_led(input logic [2:0] m);
        led_mask = m; led_req = 1'b1;
        tick();
        led_req = 1'b0;
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] b;
        case ($urandom_range(0, 11))
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = 8'hE1;
            3, 4: b = 8'hFA;
            5: b = 8'hFE;
            6: b = 8'hAA;
            7: b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            8: b = 8'hEE;
            default: b = 8'($urandom_range(1, 8'h83));
        endcase
        return b;
    endfunction

    logic [7:0] pause_seq [7];

    initial begin
        reset = 1'b0; rx_done_tick = 0; rx_data = 0; tx_done_tick = 0;
        led_req = 0; led_mask = 0; key_ready = 1;
        #12;
        check("reset_outputs", {tx_write, tx_data, led_busy, led_err, key_valid, key_code,
              key_ext, key_break, key_ovf}, 32'h0);
        reset = 1'b1;
        tick();

        // Plain make, then break.
        send(8'h1C);
        check("make_1C", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'h1C, 2'b00});
        send(8'hF0);
        send(8'h1C);
        check("break_1C", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'h1C, 2'b01});

        // Extended release: one event, one cycle of valid.
        send(8'hE0);
        check("prefix_no_event", key_valid, 1'b0);
        send(8'hF0);
        send(8'h75);
        check("ext_break_75", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'h75, 2'b11});
        tick();
        check("valid_one_cycle", key_valid, 1'b0);

        // Overflow while the consumer stalls.
        key_ready = 0;
        send(8'h1C);
        send(8'h32);
        check("ovf_pulse", {key_ovf, key_valid, key_code}, {1'b1, 1'b1, 8'h1C});
        key_ready = 1;
        tick();
        check("ovf_clear_and_drain", {key_ovf, key_valid}, 2'b00);

        // Full LED command.
        start_led(3'b101);
        check("led_tx_ed", {tx_write, tx_data, led_busy}, {1'b1, 8'hED, 1'b1});
        txdone();
        check("led_no_write", tx_write, 1'b0);
        send(8'hFA);
        check("led_tx_mask", {tx_write, tx_data}, {1'b1, 8'h05});
        txdone();
        send(8'hFA);
        check("led_done", {led_busy, led_err, tx_write}, 3'b000);

        // FE on every ED: three sends, then abort.
        start_led(3'b010);
        check("retry_send1", {tx_write, tx_data}, {1'b1, 8'hED});
        for (int i = 2; i <= 3; i++) begin
            txdone();
            send(8'hFE);
            check("retry_resend", {tx_write, tx_data, led_busy}, {1'b1, 8'hED, 1'b1});
        end
        txdone();
        send(8'hFE);
        check("retry_abort", {led_err, led_busy, tx_write}, 3'b100);

        // ACK timeout measured from entry into the ACK wait.
        start_led(3'b001);
        txdone();
        repeat (ACK_TIMEOUT - 1) tick();
        check("tmo_not_yet", {led_err, led_busy}, 2'b01);
        tick();
        check("tmo_abort", {led_err, led_busy}, 2'b10);
        tick();
        check("tmo_err_pulse", led_err, 1'b0);

        // Pause sequence produces no event.
        pause_seq = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        send(8'hE1);
        for (int i = 0; i < 7; i++) begin
            send(pause_seq[i]);
            check("pause_no_event", key_valid, 1'b0);
        end
        send(8'h1C);
        check("after_pause", {key_valid, key_code, key_ext, key_break}, {1'b1, 8'h1C, 2'b00});

        // Reset mid-command.
        start_led(3'b111);
        txdone();
        #2 reset = 1'b0;
        #1;
        check("midreset_outputs", {tx_write, tx_data, led_busy, led_err, key_valid}, 12'h0);
        tick();
        reset = 1'b1;
        tick();
        check("midreset_quiet", {tx_write, led_err, led_busy}, 3'b000);

        // Random traffic: busy rx phase, then sparse rx to reach timeouts.
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 3000; i++) begin
                rx_done_tick = (phase == 0) ? ($urandom_range(0, 2) == 0)
                                            : ($urandom_range(0, 60) == 0);
                rx_data      = pick_byte();
                tx_done_tick = (phase == 0) ? ($urandom_range(0, 5) == 0)
                                            : ($urandom_range(0, 40) == 0);
                led_req      = ($urandom_range(0, 15) == 0);
                led_mask     = 3'($urandom);
                key_ready    = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        rx_done_tick = 0; tx_done_tick = 0; led_req = 0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Keyboard-level controller sitting directly downstream and upstream of the PS/2 transceiver. It consumes received bytes and decodes scan-code set 2 make/break sequences, including E0/F0 prefixes, into single key events with a valid/ready handshake. It also drives the transceiver's write port to run the two-byte LED command (ED, mask) with ACK checking, resend and timeout.

## Interface
Parameters:
- ACK_TIMEOUT, 2000000: clk cycles allowed per wait state (tx completion or ACK) before abort; 20 ms at 100 MHz.
- MAX_RETRY, 2: resends allowed per command byte on FE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_done_tick  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte (transceiver data_out)
- tx_done_tick  in  1  one-cycle strobe: transmitted byte finished
- tx_write  out  1  one-cycle write strobe to transceiver
- tx_data  out  8  byte to transmit; stable from tx_write until next tx_write
- led_req  in  1  start LED update; sampled only when led_busy=0
- led_mask  in  3  {caps, num, scroll}; latched on accepted led_req
- led_busy  out  1  command in progress
- led_err  out  1  one-cycle pulse: command aborted
- key_valid  out  1  key event pending
- key_ready  in  1  consumer accepts event when key_valid && key_ready
- key_code  out  8  final scan byte
- key_ext  out  1  E0 prefix seen
- key_break  out  1  F0 prefix seen (release)
- key_ovf  out  1  one-cycle pulse: event dropped, holding register full

## Operation
- Reset (reset=0, async): all outputs 0, tx_data=8'h00, decoder in D_IDLE, command FSM in C_IDLE, counters 0.
- Byte routing per rx_done_tick: FA/FE go to command FSM when it is in C_WAIT_ACK1/2; otherwise FA/FE are discarded. All other bytes go to the decoder.
- Decoder states D_IDLE, D_PAUSE; flags ext, brk.
  - E0: set ext. F0: set brk. Both are legal in either order; F0 after E0 is the normal case.
  - E1: enter D_PAUSE, skip the next 7 bytes (3-bit counter), clear flags, return to D_IDLE. No event.
  - AA, EE, 00, FF: clear flags. No event.
  - Any other byte: emit event {code, ext, brk}, then clear flags.
- Event holding register, one deep. Emit with key_valid=0, or with key_valid && key_ready in the same cycle: load register, key_valid=1. Emit with key_valid=1 && key_ready=0: drop the new event, pulse key_ovf, keep the old event. Handshake with no new emit: key_valid→0.
- Command FSM:
  - C_IDLE: on led_req, latch mask, tx_data=ED, pulse tx_write → C_WAIT_TX1.
  - C_WAIT_TX1: on tx_done_tick → C_WAIT_ACK1.
  - C_WAIT_ACK1:
    - FA: tx_data={5'b0,mask}, pulse tx_write → C_WAIT_TX2.
    - FE: if retry<MAX_RETRY, retry++, re-pulse tx_write with ED → C_WAIT_TX1; else abort.
  - C_WAIT_TX2 / C_WAIT_ACK2: same rules as the first byte, resending the mask byte. FA in C_WAIT_ACK2 → C_IDLE.
  - retry clears when a byte is acknowledged.
  - Timeout counter clears on each state entry and counts in every wait state. Reaching ACK_TIMEOUT aborts.
  - Abort: pulse led_err, → C_IDLE.
- led_busy=1 in every state except C_IDLE. led_req while busy is ignored (not queued).
- Decoder and command FSM run concurrently. Scan bytes arriving during a command are decoded normally.

## Timing
- tx_write is asserted the cycle after led_req is sampled, and the cycle after a qualifying FA/FE rx_done_tick.
- key_valid rises the cycle after the rx_done_tick of the final scan byte. Decode latency is 1 clk regardless of prefix count.
- led_busy falls the cycle after the final FA. led_err and the led_busy fall occur in the same cycle.
- Timeout counter width is $clog2(ACK_TIMEOUT+1). Abort fires exactly ACK_TIMEOUT cycles after state entry if no qualifying strobe arrives.
- A qualifying strobe in the same cycle as the timeout wins (no abort).
- rx_done_tick and tx_done_tick in the same cycle are both processed.
- Reset mid-command: FSM returns to C_IDLE, no led_err, no tx_write.

## Test plan
- Bytes 1C → key_valid, key_code=1C, ext=0, brk=0. Then bytes F0,1C → key_code=1C, brk=1.
- Bytes E0,F0,75 with key_ready=1 → single event: code=75, ext=1, brk=1, key_valid high for 1 cycle.
- key_ready=0; send 1C then 32 → key_code stays 1C, key_ovf pulses once. Raise key_ready → key_valid drops next cycle.
- led_req with mask=3'b101: tx ED, tx_done, FA → tx_write with tx_data=05; tx_done, FA → led_busy=0, no led_err.
- ED answered FE three times with MAX_RETRY=2 → ED sent 3 times total, then led_err pulse, led_busy=0.
- ACK_TIMEOUT=100; no FA after ED's tx_done → led_err exactly 100 cycles after entering C_WAIT_ACK1. E1 followed by 7 bytes → no key event.
